// File: rtl/vx_issue_sched_pkg.sv
// Shared types, execute-unit codes and sizing helpers for the warp issue scheduler.
package vx_issue_sched_pkg;

  localparam int WID_BITS = 2;
  localparam int EX_W     = 3;

  typedef logic [WID_BITS-1:0] wid_t;
  typedef logic [EX_W-1:0]     ex_type_t;

  localparam ex_type_t EX_ALU = 3'd0;
  localparam ex_type_t EX_LSU = 3'd1;
  localparam ex_type_t EX_CSR = 3'd2;
  localparam ex_type_t EX_FPU = 3'd3;
  localparam ex_type_t EX_GPU = 3'd4;

  // Starvation counter must hold 0..limit inclusive.
  function automatic int starve_ctr_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/vx_issue_sched_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module vx_issue_sched_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Scan farthest offset first so the closest hit to ptr is the last write.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + IW'(k);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/vx_issue_sched.sv
// Per-warp issue scheduler: picks one hazard-free warp whose unit is ready,
// pops its buffer head and registers the pick for dispatch.
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter int NUM_WARPS     = 4,
  parameter int EX_BITS       = 3,
  parameter int NUM_EX_UNITS  = 5,
  parameter int STARVE_LIMIT  = 15,
  parameter int PERF_CTR_BITS = 44,
  localparam int WW = $clog2(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         warp_valid,
  input  logic [NUM_WARPS-1:0]         warp_hazard_free,
  input  logic [NUM_WARPS*EX_BITS-1:0] warp_ex_type,
  input  logic [NUM_EX_UNITS-1:0]      unit_ready,
  output logic [NUM_WARPS-1:0]         grant,
  output logic                         out_valid,
  output logic [WW-1:0]                out_wid,
  output logic [EX_BITS-1:0]           out_ex_type,
  input  logic                         out_ready,
  output logic [PERF_CTR_BITS-1:0]     perf_sched_stalls
);

  localparam int CW = starve_ctr_w(STARVE_LIMIT);

  logic [NUM_WARPS-1:0][CW-1:0] starve_ctr;
  logic [NUM_WARPS-1:0]         unit_ok, eligible, urgent;
  logic [NUM_WARPS-1:0]         urg_gnt, all_gnt;
  logic [WW-1:0]                urg_idx, all_idx, sel_wid, rr_ptr;
  logic                         urg_any, all_any, can_load;
  logic [EX_BITS-1:0]           sel_ex;

  assign can_load = !out_valid || out_ready;

  // Codes outside 0..NUM_EX_UNITS-1 match no unit and stay ineligible.
  always_comb begin
    unit_ok = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      for (int u = 0; u < NUM_EX_UNITS; u++)
        if (warp_ex_type[w*EX_BITS +: EX_BITS] == EX_BITS'(u))
          unit_ok[w] = unit_ready[u];
  end

  assign eligible = warp_valid & warp_hazard_free & unit_ok & {NUM_WARPS{can_load}};

  vx_issue_sched_rr_pick #(.N(NUM_WARPS)) u_pick_urgent (
    .req (urgent & eligible),
    .ptr (rr_ptr),
    .gnt (urg_gnt),
    .idx (urg_idx),
    .any (urg_any)
  );

  vx_issue_sched_rr_pick #(.N(NUM_WARPS)) u_pick_all (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (all_gnt),
    .idx (all_idx),
    .any (all_any)
  );

  assign sel_wid = urg_any ? urg_idx : all_idx;
  assign sel_ex  = warp_ex_type[int'(sel_wid)*EX_BITS +: EX_BITS];
  assign grant   = (reset || !all_any) ? '0 : (urg_any ? urg_gnt : all_gnt);

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_starve
    assign urgent[w] = (starve_ctr[w] == CW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
      if (reset)
        starve_ctr[w] <= '0;
      else if (grant[w] || !warp_valid[w])
        starve_ctr[w] <= '0;
      else if (warp_hazard_free[w] && !urgent[w])
        starve_ctr[w] <= starve_ctr[w] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr            <= '0;
      out_valid         <= 1'b0;
      out_wid           <= '0;
      out_ex_type       <= '0;
      perf_sched_stalls <= '0;
    end else begin
      // A new pick overwrites a draining entry in the same cycle.
      if (|grant) begin
        rr_ptr      <= sel_wid + WW'(1);
        out_valid   <= 1'b1;
        out_wid     <= sel_wid;
        out_ex_type <= sel_ex;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if ((|warp_valid) && !(|grant))
        perf_sched_stalls <= perf_sched_stalls + PERF_CTR_BITS'(1);
    end
  end

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed bench for the warp issue scheduler with a scoreboard of expected picks.
module tb_vx_issue_sched;
  import vx_issue_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wv, hf;
  logic [11:0] ext;
  logic [4:0]  ur;
  logic        ordy;
  logic [3:0]  grant;
  logic        out_valid;
  logic [1:0]  out_wid;
  logic [2:0]  out_ex_type;
  logic [43:0] perf;

  always #5 clk = ~clk;

  vx_issue_sched #(
    .NUM_WARPS(4), .EX_BITS(3), .NUM_EX_UNITS(5), .STARVE_LIMIT(3), .PERF_CTR_BITS(44)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .warp_valid       (wv),
    .warp_hazard_free (hf),
    .warp_ex_type     (ext),
    .unit_ready       (ur),
    .grant            (grant),
    .out_valid        (out_valid),
    .out_wid          (out_wid),
    .out_ex_type      (out_ex_type),
    .out_ready        (ordy),
    .perf_sched_stalls(perf)
  );

  typedef struct packed {
    logic [1:0] wid;
    logic [2:0] ex;
  } exp_t;

  exp_t    sbq[$];
  exp_t    cur;
  logic    exp_ov;
  longint  exp_perf;
  int      checks = 0;
  int      failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: grant checked mid-cycle, registered output checked after the edge.
  task automatic cycle(input string tag, input logic [3:0] eg);
    exp_t e;
    e = '0;
    @(negedge clk);
    chk({tag, " grant"}, 64'(grant), 64'(eg));
    if (eg != 4'b0) begin
      for (int w = 0; w < 4; w++)
        if (eg[w]) begin
          e.wid = 2'(w);
          e.ex  = ext[w*3 +: 3];
        end
      sbq.push_back(e);
    end
    if ((|wv) && eg == 4'b0) exp_perf++;
    @(posedge clk);
    #1;
    if (eg != 4'b0) begin
      cur    = sbq.pop_front();
      exp_ov = 1'b1;
    end else if (ordy) begin
      exp_ov = 1'b0;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk({tag, " out_wid"}, 64'(out_wid), 64'(cur.wid));
      chk({tag, " out_ex_type"}, 64'(out_ex_type), 64'(cur.ex));
    end
    chk({tag, " perf"}, 64'(perf), 64'(exp_perf));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, " grant"}, 64'(grant), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    exp_ov   = 1'b0;
    exp_perf = 0;
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_wid"}, 64'(out_wid), 64'd0);
    chk({tag, " out_ex_type"}, 64'(out_ex_type), 64'd0);
    chk({tag, " perf"}, 64'(perf), 64'd0);
  endtask

  initial begin
    reset = 1'b1; wv = 4'hf; hf = 4'hf; ext = '0; ur = 5'h1f; ordy = 1'b1;
    exp_ov = 1'b0; exp_perf = 0; cur = '0;
    do_reset("rst0");
    do_reset("rst1");

    wv = 4'b0001; ext = '0;
    cycle("basic", 4'b0001);

    wv = 4'hf; ext = {EX_FPU, EX_CSR, EX_LSU, EX_ALU};
    cycle("rr0", 4'b0010);
    cycle("rr1", 4'b0100);
    cycle("rr2", 4'b1000);
    cycle("rr3", 4'b0001);
    cycle("rr4", 4'b0010);
    wv = 4'b0;
    cycle("drain0", 4'b0000);

    wv = 4'b0011; ext = {EX_FPU, EX_CSR, EX_ALU, EX_LSU}; ur = 5'b11101;
    cycle("ublk", 4'b0010);
    wv = 4'b0001; ur = 5'b11111;
    cycle("ublk_rel", 4'b0001);

    ext = {EX_FPU, EX_CSR, EX_ALU, 3'd7};
    cycle("bad_ex", 4'b0000);
    wv = 4'b0;
    cycle("drain1", 4'b0000);

    wv = 4'hf; ext = {EX_FPU, EX_CSR, EX_LSU, EX_ALU}; ordy = 1'b0;
    cycle("bp_load", 4'b0010);
    for (int i = 0; i < 5; i++) cycle("bp_stall", 4'b0000);
    ordy = 1'b1;
    cycle("bp_release", 4'b0100);
    wv = 4'b0;
    cycle("drain2", 4'b0000);

    wv = 4'b1000;
    cycle("stv_pre", 4'b1000);
    wv = 4'b0111; ur = 5'b11011;
    cycle("stv_a", 4'b0001);
    cycle("stv_b", 4'b0010);
    wv = 4'b1100;
    cycle("stv_c", 4'b1000);
    wv = 4'b0111; ur = 5'b11111;
    cycle("stv_boost", 4'b0100);

    wv = 4'b1000;
    do_reset("rst_mid");
    wv = 4'b1010;
    cycle("post_ptr", 4'b0010);
    wv = 4'b1000;
    cycle("post_w3", 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
